// File: rtl/ula_ctrl_pkg.sv
// Shared definitions for the ula command front-end: opcode values,
// FSM state encoding, datapath widths and the golden ALU result function.
package ula_pkg;

  localparam int OP_W  = 4;
  localparam int RES_W = 8;

  localparam logic [OP_W-1:0] OP_ADD = 4'd0;
  localparam logic [OP_W-1:0] OP_SUB = 4'd1;
  localparam logic [OP_W-1:0] OP_MUL = 4'd2;
  localparam logic [OP_W-1:0] OP_DIV = 4'd3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Result the ALU is expected to produce; illegal opcodes and divide by
  // zero both yield zero.
  function automatic logic [RES_W-1:0] ula_expected(
    input logic [OP_W-1:0] op,
    input logic [OP_W-1:0] a,
    input logic [OP_W-1:0] b
  );
    logic [RES_W-1:0] ea;
    logic [RES_W-1:0] eb;
    ea = {4'b0, a};
    eb = {4'b0, b};
    case (op)
      OP_ADD:  ula_expected = ea + eb;
      OP_SUB:  ula_expected = ea - eb;
      OP_MUL:  ula_expected = ea * eb;
      OP_DIV:  ula_expected = (b == '0) ? '0 : (ea / eb);
      default: ula_expected = '0;
    endcase
  endfunction

endpackage

// File: rtl/ula_ctrl_ref_model.sv
// Combinational reference for the ula result, used by the optional
// result checker (ULA_CHECK_EN) inside ula_ctrl.
module ula_ref_model
  import ula_pkg::*;
(
  input  logic [OP_W-1:0]  i_op,
  input  logic [OP_W-1:0]  i_a,
  input  logic [OP_W-1:0]  i_b,
  output logic [RES_W-1:0] o_expected
);

  assign o_expected = ula_expected(i_op, i_a, i_b);

endmodule

// File: rtl/ula_ctrl.sv
// Command front-end for the combinational 4-bit ula: registers a command
// onto the ula inputs, waits SETTLE_CYCLES, captures the result with status
// flags and holds it until the consumer takes it.
// Optional macro ULA_CHECK_EN adds a result checker with a saturating
// mismatch counter; without it the checker outputs are tied to zero.
module ula_ctrl
  import ula_pkg::*;
#(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_op,
  input  logic [3:0]           cmd_a,
  input  logic [3:0]           cmd_b,
  output logic [3:0]           ula_switchs,
  output logic [3:0]           ula_A,
  output logic [3:0]           ula_B,
  input  logic [7:0]           ula_saida,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [7:0]           rsp_data,
  output logic [3:0]           rsp_op,
  output logic                 rsp_div0,
  output logic                 rsp_neg,
  output logic                 rsp_illegal,
  output logic                 chk_mismatch,
  output logic [ERR_CNT_W-1:0] chk_err_count
);

  // A settle time below one cycle is meaningless; clamp it.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int CNT_W      = $clog2(SETTLE_EFF + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_EFF - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0]  r_sh_op;
  logic [OP_W-1:0]  r_sh_a;
  logic [OP_W-1:0]  r_sh_b;
  logic [OP_W-1:0]  r_ula_sw;
  logic [OP_W-1:0]  r_ula_a;
  logic [OP_W-1:0]  r_ula_b;
  logic             r_cmd_ready;
  logic             r_rsp_valid;
  logic [RES_W-1:0] r_rsp_data;
  logic [OP_W-1:0]  r_rsp_op;
  logic             r_rsp_div0;
  logic             r_rsp_neg;
  logic             r_rsp_illegal;

  logic             w_capture;
  logic             w_illegal;
  logic [RES_W-1:0] w_result;

  // Flags and the illegal-op override come from the shadow operands so they
  // do not depend on what the ALU actually returned.
  assign w_capture = (r_state == ST_SETTLE) && (r_cnt == '0);
  assign w_illegal = (r_sh_op > OP_DIV);
  assign w_result  = w_illegal ? '0 : ula_saida;

  // Command/settle/response sequencing with all outputs registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_sh_op       <= '0;
      r_sh_a        <= '0;
      r_sh_b        <= '0;
      r_ula_sw      <= '0;
      r_ula_a       <= '0;
      r_ula_b       <= '0;
      r_cmd_ready   <= 1'b1;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_op      <= '0;
      r_rsp_div0    <= 1'b0;
      r_rsp_neg     <= 1'b0;
      r_rsp_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_sh_op     <= cmd_op;
            r_sh_a      <= cmd_a;
            r_sh_b      <= cmd_b;
            r_ula_sw    <= cmd_op;
            r_ula_a     <= cmd_a;
            r_ula_b     <= cmd_b;
            r_cnt       <= CNT_LOAD;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= w_result;
            r_rsp_op      <= r_sh_op;
            r_rsp_div0    <= (r_sh_op == OP_DIV) && (r_sh_b == '0);
            r_rsp_neg     <= (r_sh_op == OP_SUB) && (r_sh_a < r_sh_b);
            r_rsp_illegal <= w_illegal;
            r_state       <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign ula_switchs = r_ula_sw;
  assign ula_A       = r_ula_a;
  assign ula_B       = r_ula_b;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_op      = r_rsp_op;
  assign rsp_div0    = r_rsp_div0;
  assign rsp_neg     = r_rsp_neg;
  assign rsp_illegal = r_rsp_illegal;

`ifdef ULA_CHECK_EN
  logic [RES_W-1:0]     w_expected;
  logic                 w_mismatch;
  logic                 r_chk_mismatch;
  logic [ERR_CNT_W-1:0] r_chk_err_count;

  ula_ref_model u_ref_model (
    .i_op       (r_sh_op),
    .i_a        (r_sh_a),
    .i_b        (r_sh_b),
    .o_expected (w_expected)
  );

  // Illegal opcodes are never counted as mismatches: their data is forced.
  assign w_mismatch = !w_illegal && (ula_saida != w_expected);

  // Mismatch flag is captured with the response; counter saturates.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_chk_mismatch  <= 1'b0;
      r_chk_err_count <= '0;
    end else if (w_capture) begin
      r_chk_mismatch <= w_mismatch;
      if (w_mismatch && (r_chk_err_count != '1)) begin
        r_chk_err_count <= r_chk_err_count + ERR_CNT_W'(1);
      end
    end
  end

  assign chk_mismatch  = r_chk_mismatch;
  assign chk_err_count = r_chk_err_count;
`else
  logic w_unused;
  assign w_unused      = w_capture;
  assign chk_mismatch  = 1'b0;
  assign chk_err_count = '0;
`endif

endmodule

// File: tb/tb_ula_ctrl.sv
// Bench for ula_ctrl: two instances (settle 1 and settle 4) share the
// command stream; each is fed by its own behavioural ula.
module tb_ula_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       cmd_valid;
  logic [3:0] cmd_op, cmd_a, cmd_b;
  logic       rsp_ready;
  logic       stub_zero;

  logic       cmd_ready   [2];
  logic [3:0] sw          [2];
  logic [3:0] ua          [2];
  logic [3:0] ub          [2];
  logic [7:0] saida       [2];
  logic       rsp_valid   [2];
  logic [7:0] rsp_data    [2];
  logic [3:0] rsp_op      [2];
  logic       rsp_div0    [2];
  logic       rsp_neg     [2];
  logic       rsp_illegal [2];
  logic       mism        [2];
  logic [7:0] errc        [2];

  int checks = 0;
  int errors = 0;

  // Expected result from the operation's arithmetic meaning; illegal -> 0.
  function automatic logic [7:0] model_data(input logic [3:0] op, a, b);
    int r;
    case (int'(op))
      0: r = int'(a) + int'(b);
      1: r = int'(a) - int'(b);
      2: r = int'(a) * int'(b);
      3: r = (b == 0) ? 0 : int'(a) / int'(b);
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  // Behavioural ula: garbage for illegal opcodes so forcing to zero is visible.
  function automatic logic [7:0] alu(input logic [3:0] op, a, b);
    return (op > 3) ? 8'hA5 : model_data(op, a, b);
  endfunction

  assign saida[0] = stub_zero ? 8'h00 : alu(sw[0], ua[0], ub[0]);
  assign saida[1] = stub_zero ? 8'h00 : alu(sw[1], ua[1], ub[1]);

  ula_ctrl #(.SETTLE_CYCLES(1), .ERR_CNT_W(8)) u_s1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ula_switchs(sw[0]), .ula_A(ua[0]), .ula_B(ub[0]), .ula_saida(saida[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[0]),
    .rsp_op(rsp_op[0]), .rsp_div0(rsp_div0[0]), .rsp_neg(rsp_neg[0]),
    .rsp_illegal(rsp_illegal[0]), .chk_mismatch(mism[0]), .chk_err_count(errc[0])
  );

  ula_ctrl #(.SETTLE_CYCLES(4), .ERR_CNT_W(8)) u_s4 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .ula_switchs(sw[1]), .ula_A(ua[1]), .ula_B(ub[1]), .ula_saida(saida[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_data(rsp_data[1]),
    .rsp_op(rsp_op[1]), .rsp_div0(rsp_div0[1]), .rsp_neg(rsp_neg[1]),
    .rsp_illegal(rsp_illegal[1]), .chk_mismatch(mism[1]), .chk_err_count(errc[1])
  );

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[dut%0d] actual=%0h required=%0h", nm, i, act, req);
    end
  endtask

  task automatic check_reset_state();
    for (int i = 0; i < 2; i++) begin
      chk("rst_cmd_ready", i, cmd_ready[i], 1);
      chk("rst_switchs", i, sw[i], 0);
      chk("rst_A", i, ua[i], 0);
      chk("rst_B", i, ub[i], 0);
      chk("rst_rsp_valid", i, rsp_valid[i], 0);
      chk("rst_rsp_data", i, rsp_data[i], 0);
      chk("rst_rsp_op", i, rsp_op[i], 0);
      chk("rst_flags", i, {rsp_div0[i], rsp_neg[i], rsp_illegal[i]}, 0);
      chk("rst_chk", i, {mism[i], errc[i]}, 0);
    end
  endtask

  // One full transaction on both instances: accept, latency, optional
  // backpressure with an ignored concurrent command, response, handshake.
  task automatic issue(input logic [3:0] op, a, b, input logic [7:0] ed,
                       input logic e0, en, ei, input int hold, input bit poke,
                       input logic em);
    int lat[2];
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk("cmd_ready_idle", i, cmd_ready[i], 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("ula_drive", i, {sw[i], ua[i], ub[i]}, {op, a, b});
      chk("busy_cmd_ready", i, cmd_ready[i], 0);
    end
    lat[0] = 0; lat[1] = 0;
    for (int k = 1; k <= 12 && (lat[0] == 0 || lat[1] == 0); k++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) if (lat[i] == 0 && rsp_valid[i]) lat[i] = k;
    end
    chk("latency", 0, lat[0], 1);
    chk("latency", 1, lat[1], 4);
    if (poke) begin
      @(negedge clk);
      cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~a; cmd_b = ~b;
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      for (int i = 0; i < 2; i++) begin
        chk("hold_valid", i, rsp_valid[i], 1);
        chk("hold_data", i, rsp_data[i], ed);
        chk("hold_cmd_ready", i, cmd_ready[i], 0);
      end
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rsp_data", i, rsp_data[i], ed);
      chk("rsp_op", i, rsp_op[i], op);
      chk("rsp_div0", i, rsp_div0[i], e0);
      chk("rsp_neg", i, rsp_neg[i], en);
      chk("rsp_illegal", i, rsp_illegal[i], ei);
      chk("chk_mismatch", i, mism[i], em);
      chk("ula_kept", i, {sw[i], ua[i], ub[i]}, {op, a, b});
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("post_rsp_valid", i, rsp_valid[i], 0);
      chk("post_cmd_ready", i, cmd_ready[i], 1);
    end
  endtask

  typedef struct {
    logic [3:0] op, a, b;
    logic [7:0] data;
    logic       div0, neg, ill;
    int         hold;
    bit         poke;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0] op, a, b;

    vecs[0] = '{4'h0, 4'hF, 4'hF, 8'h1E, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[1] = '{4'h1, 4'h2, 4'h3, 8'hFF, 1'b0, 1'b1, 1'b0, 0, 1'b0};
    vecs[2] = '{4'h1, 4'h4, 4'h4, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0};
    vecs[3] = '{4'h2, 4'hF, 4'hF, 8'hE1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    vecs[4] = '{4'h3, 4'h1, 4'h0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0};
    vecs[5] = '{4'h3, 4'h8, 4'h2, 8'h04, 1'b0, 1'b0, 1'b0, 2, 1'b0};
    vecs[6] = '{4'h7, 4'h3, 4'h5, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    vecs[7] = '{4'h2, 4'h8, 4'h8, 8'h40, 1'b0, 1'b0, 1'b0, 5, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0; stub_zero = 1'b0;
    cmd_op = '0; cmd_a = '0; cmd_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++)
      issue(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].data, vecs[v].div0,
            vecs[v].neg, vecs[v].ill, vecs[v].hold, vecs[v].poke, 1'b0);

    // Reset right after accept: settle-1 is at its capture edge, settle-4
    // is mid-count; neither may produce a response.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 4'h2; cmd_a = 4'h3; cmd_b = 4'h3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state();
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen = 0;
      for (int k = 0; k < 10; k++) begin
        @(posedge clk); #1;
        if (rsp_valid[0] || rsp_valid[1]) seen++;
      end
      chk("no_rsp_after_reset", 0, seen, 0);
    end

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(4, 15));
      a  = 4'($urandom_range(0, 15));
      b  = 4'($urandom_range(0, 15));
      issue(op, a, b, model_data(op, a, b), (op == 3) && (b == 0),
            (op == 1) && (a < b), op > 3, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

`ifdef ULA_CHECK_EN
    stub_zero = 1'b1;
    issue(4'h0, 4'h4, 4'h1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) chk("err_count_one", i, errc[i], 1);
    stub_zero = 1'b0;
    issue(4'h0, 4'h4, 4'h1, 8'h05, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) chk("err_count_stays", i, errc[i], 1);
`else
    stub_zero = 1'b1;
    issue(4'h0, 4'h4, 4'h1, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) chk("err_count_tied", i, errc[i], 0);
    stub_zero = 1'b0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_ctrl.md
Name: ula_ctrl

Overview:
Sequential command front-end for the combinational 4-bit `ula` (ALU).
- Accepts operation commands on a valid/ready interface and drives the `ula` switchs/A/B inputs from registers.
- Waits a programmable settle time, then captures the 8-bit `saida` into a held response with status flags.
- Sits between a CPU/test sequencer and `ula`, on the issuing/consuming side of the `ula` port set.

Parameters:
SETTLE_CYCLES, 1, cycles between driving `ula` inputs and capturing `saida`; values below 1 are treated as 1.
ERR_CNT_W, 8, width of the checker error counter (used only with ULA_CHECK_EN).

Ports:
clk  input  1  Clock, rising edge.
rst_n  input  1  Synchronous reset, active-low.
cmd_valid  input  1  Command present.
cmd_ready  output  1  Block can accept a command.
cmd_op  input  4  Opcode: 0 add, 1 sub, 2 mul, 3 div, 4..15 illegal.
cmd_a  input  4  Operand A.
cmd_b  input  4  Operand B.
ula_switchs  output  4  Registered opcode driven to `ula`.
ula_A  output  4  Registered operand A driven to `ula`.
ula_B  output  4  Registered operand B driven to `ula`.
ula_saida  input  8  Combinational result from `ula`.
rsp_valid  output  1  Response present.
rsp_ready  input  1  Consumer accepts the response.
rsp_data  output  8  Captured result.
rsp_op  output  4  Opcode of this response.
rsp_div0  output  1  Div with B==0.
rsp_neg  output  1  Sub with A<B, so rsp_data is an 8-bit two's-complement negative.
rsp_illegal  output  1  Opcode was 4..15.
chk_mismatch  output  1  Checker: captured value differs from the model.
chk_err_count  output  ERR_CNT_W  Checker: saturating mismatch count.

Behaviour:
- Reset: sync, active-low; rst_n=0 at a rising edge applies it. Afterwards every output is 0 except cmd_ready=1. State is IDLE and the settle counter is 0.
- States: IDLE, SETTLE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready: latch op/a/b into ula_switchs/ula_A/ula_B and into internal shadow registers. Load the counter with SETTLE_CYCLES-1 and go to SETTLE.
- SETTLE:
  - cmd_ready=0.
  - Counter nonzero: decrement.
  - Counter zero: capture and go to RESP. Capture sets rsp_data=ula_saida, rsp_op, the flags, and rsp_valid=1.
- Latency: accept at edge T gives rsp_valid=1 after edge T+SETTLE_CYCLES.
- RESP:
  - rsp_valid, rsp_data and all flags hold stable until rsp_valid&&rsp_ready.
  - On that handshake edge: rsp_valid returns to 0 and the state goes to IDLE.
  - cmd_ready returns to 1 in the following cycle; there is no same-cycle turnaround.
- Flags are computed from the shadow operands, not from ula_saida:
  - rsp_div0 = (op==3)&&(b==0).
  - rsp_neg = (op==1)&&(a<b).
  - rsp_illegal = op>3.
- Illegal opcode: same latency; rsp_data forced to 8'h00 regardless of ula_saida.
- ula_switchs/A/B keep the last command's values after the response; they are not cleared.
- cmd_valid while not IDLE: ignored; no buffering.
- Reset during SETTLE or RESP: the in-flight command is dropped; no response is emitted.
- Throughput: one command per SETTLE_CYCLES+2 cycles at best.

Optional Feature:
- Macro: ULA_CHECK_EN.
- Defined:
  - An internal reference model computes the expected value from the shadow operands:
    - add: zero-extended sum.
    - sub: ({4'b0,a}-{4'b0,b}) mod 256.
    - mul: 8-bit product.
    - div: b==0 → 8'h00, else a/b.
  - At capture, chk_mismatch = (ula_saida != expected) for legal opcodes, else 0; it is held with the response.
  - chk_err_count increments by 1 per mismatch and saturates at all-ones.
- Not defined: chk_mismatch and chk_err_count are tied to 0 and no model logic exists. Ports remain, so the interface is stable.

Decomposition:
- Package ula_pkg:
  - Opcode constants OP_ADD=4'd0, OP_SUB=4'd1, OP_MUL=4'd2, OP_DIV=4'd3.
  - State encoding constants ST_IDLE, ST_SETTLE, ST_RESP.
  - Opcode width 4 and result width 8.
- Sub-module ula_ref_model: combinational expected-result function, instantiated only under ULA_CHECK_EN.

Test Plan:
- op=0, A=4'hF, B=4'hF, SETTLE_CYCLES=1 → ula_switchs=0/A=F/B=F after accept; rsp_valid after T+1; rsp_data=8'h1E; all flags 0.
- op=1, A=2, B=3 → rsp_data=8'hFF, rsp_neg=1. Then op=1, A=4, B=4 → rsp_data=8'h00, rsp_neg=0.
- op=2, A=F, B=F → rsp_data=8'hE1. Then op=3, A=1, B=0 → rsp_data=8'h00, rsp_div0=1. Then op=3, A=8, B=2 → 8'h04.
- Backpressure: hold rsp_ready=0 for 5 cycles after op=2, A=8, B=8 → rsp_data=8'h40 stable, cmd_ready=0, a concurrent cmd_valid is ignored. rsp_ready=1 → rsp_valid=0 next edge, cmd_ready=1 the cycle after.
- rst_n=0 during SETTLE (SETTLE_CYCLES=4) → next edge: all outputs 0, cmd_ready=1; no rsp_valid ever appears for that command. op=7 → rsp_illegal=1, rsp_data=8'h00.
- ULA_CHECK_EN with a `ula` stub returning 8'h00 for op=0, A=4, B=1 → chk_mismatch=1, chk_err_count=1. A correct result next → chk_mismatch=0, count stays 1.
